// File: rtl/coef_bank_loader.sv
// coef_bank_loader: streams N_COEF coefficients into four coefficient banks
// using the conflict-free bank/address map the NTT core reads with.
// Kyber (KD_mode=0) writes one 12-bit word per coefficient; Dilithium
// (KD_mode=1) writes the low and high 12-bit halves to two banks at once.
// Optional feature macro: COEF_RANGE_CHK_EN builds the sticky out-of-range
// flag on err; without it err is tied to 0 and no comparator exists.
module coef_bank_loader #(
  parameter int N_COEF = 256,
  parameter int ADDR_W = 7,
  parameter int BANK_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              KD_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [23:0]       s_data,
  output logic [3:0]        wen,
  output logic [ADDR_W-1:0] waddr_0,
  output logic [ADDR_W-1:0] waddr_1,
  output logic [ADDR_W-1:0] waddr_2,
  output logic [ADDR_W-1:0] waddr_3,
  output logic [BANK_W-1:0] wdata_0,
  output logic [BANK_W-1:0] wdata_1,
  output logic [BANK_W-1:0] wdata_2,
  output logic [BANK_W-1:0] wdata_3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_COEF - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   n_q;
  logic               mode_q;
  logic               done_q;
  logic [3:0]         wen_q,   wen_d;
  logic [ADDR_W-1:0]  waddr_q [4];
  logic [ADDR_W-1:0]  waddr_d [4];
  logic [BANK_W-1:0]  wdata_q [4];
  logic [BANK_W-1:0]  wdata_d [4];

  logic        hs;
  logic        start_acc;
  logic [1:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic [5:0]  row;

  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign hs        = s_valid && s_ready;
  assign start_acc = (state_q == IDLE) && start;

  // Base-4 digit sum of n (mod 4) picks the bank; the upper six bits pick the row.
  assign bank_lo = n_q[1:0] + n_q[3:2] + n_q[5:4] + n_q[7:6];
  assign bank_hi = bank_lo + 2'd2;
  assign row     = n_q[7:2];

  // Next write-port values: enable only the bank(s) hit by this handshake.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wen_d = '0;
    for (int i = 0; i < 4; i++) begin
      waddr_d[i] = waddr_q[i];
      wdata_d[i] = wdata_q[i];
    end
    if (hs) begin
      wen_d[bank_lo]   = 1'b1;
      waddr_d[bank_lo] = ADDR_W'({1'b0, row});
      wdata_d[bank_lo] = s_data[BANK_W-1:0];
      if (mode_q) begin
        wen_d[bank_hi]   = 1'b1;
        waddr_d[bank_hi] = ADDR_W'({1'b1, row});
        wdata_d[bank_hi] = s_data[2*BANK_W-1:BANK_W];
      end
    end
  end

  // Load FSM, coefficient counter, mode latch and registered write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            n_q     <= '0;
            mode_q  <= KD_mode;
          end
        end
        LOAD: begin
          if (hs) begin
            n_q <= n_q + 1'b1;
            if (n_q == LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COEF_RANGE_CHK_EN
  logic err_q;
  logic coef_bad;

  assign coef_bad = mode_q ? (s_data >= 24'd8380417) : (s_data[11:0] >= 12'd3329);

  // Sticky range flag: cleared by an accepted start, set after any bad handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (hs && coef_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign err = 1'b0;
`endif

  assign wen     = wen_q;
  assign done    = done_q;
  assign waddr_0 = waddr_q[0];
  assign waddr_1 = waddr_q[1];
  assign waddr_2 = waddr_q[2];
  assign waddr_3 = waddr_q[3];
  assign wdata_0 = wdata_q[0];
  assign wdata_1 = wdata_q[1];
  assign wdata_2 = wdata_q[2];
  assign wdata_3 = wdata_q[3];

endmodule

// File: tb/tb_coef_bank_loader.sv
// Self-checking bench for coef_bank_loader: randomized streams with gaps and
// stray start pulses, checked against a bank-map reference model. The
// COEF_RANGE_CHK_EN macro selects whether the model expects err activity.
module tb_coef_bank_loader;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        KD_mode;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic [3:0]  wen;
  logic [6:0]  waddr_0, waddr_1, waddr_2, waddr_3;
  logic [11:0] wdata_0, wdata_1, wdata_2, wdata_3;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Model state: last value presented on each bank port, sticky error flag.
  logic [6:0]  exp_waddr [4];
  logic [11:0] exp_wdata [4];
  bit          exp_err;

  // Stimulus and per-coefficient observations of the most recent load.
  logic [23:0] coef      [N];
  logic [3:0]  obs_wen   [N];
  logic [6:0]  obs_waddr [N][4];
  logic [11:0] obs_wdata [N][4];
  logic        obs_done  [N];
  logic        obs_err   [N];

  coef_bank_loader dut (
    .clk(clk), .rst(rst), .start(start), .KD_mode(KD_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .wen(wen),
    .waddr_0(waddr_0), .waddr_1(waddr_1), .waddr_2(waddr_2), .waddr_3(waddr_3),
    .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2), .wdata_3(wdata_3),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Bank of coefficient n: sum of its four base-4 digits, modulo 4.
  function automatic logic [1:0] ref_bank(input int n);
    return 2'(((n % 4) + ((n / 4) % 4) + ((n / 16) % 4) + ((n / 64) % 4)) % 4);
  endfunction

  function automatic bit ref_bad(input bit kd, input logic [23:0] c);
    return kd ? (int'(c) >= 8380417) : (int'(c[11:0]) >= 3329);
  endfunction

  // Drive one cycle of inputs (at a falling edge) and return at the next falling edge.
  task automatic step(input logic st, input logic kd, input logic v, input logic [23:0] d);
    start = st; KD_mode = kd; s_valid = v; s_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_coef(input bit kd);
    for (int i = 0; i < N; i++)
      coef[i] = kd ? 24'($urandom_range(0, 8380416))
                   : {12'($urandom), 12'($urandom_range(0, 3328))};
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      exp_waddr[i] = '0;
      exp_wdata[i] = '0;
    end
    exp_err = 1'b0;
  endtask

  // Start a load and stream coef[] through it; stop early when abort_at is reached.
  task automatic run_load(input bit kd, input bit gaps, input bit valid_on_start, input int abort_at);
    int n = 0;
    int cyc = 0;
    int wr_cycles = 0;
    int done_cnt = 0;
    int bad_pairs = 0;
    int seen [4][128];
    logic [3:0] ew;
    logic [1:0] b;
    logic [1:0] bh;
    int a;
    bit v;
    bit exp_done;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 128; j++) seen[i][j] = 0;

    step(1'b1, kd, valid_on_start, 24'hFFFFFF);
    exp_err = 1'b0;
    tests++;
    if (wen !== 4'b0000 || s_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL start_accept: wen=%b s_ready=%b busy=%b done=%b err=%b, want 0000 1 1 0 0",
               wen, s_ready, busy, done, err);
    end

    while (n < N && n != abort_at && cyc < 4000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), v, v ? coef[n] : 24'($urandom));
      cyc++;
      ew = '0;
      exp_done = 1'b0;
      if (v) begin
        b = ref_bank(n);
        a = n / 4;
        ew[b] = 1'b1;
        exp_waddr[b] = 7'(a);
        exp_wdata[b] = coef[n][11:0];
        seen[b][a]++;
        if (kd) begin
          bh = b + 2'd2;
          ew[bh] = 1'b1;
          exp_waddr[bh] = 7'(64 + a);
          exp_wdata[bh] = coef[n][23:12];
          seen[bh][64 + a]++;
        end
`ifdef COEF_RANGE_CHK_EN
        if (ref_bad(kd, coef[n])) exp_err = 1'b1;
`endif
        exp_done = (n == N - 1);
        obs_wen[n] = wen;
        obs_waddr[n][0] = waddr_0; obs_waddr[n][1] = waddr_1;
        obs_waddr[n][2] = waddr_2; obs_waddr[n][3] = waddr_3;
        obs_wdata[n][0] = wdata_0; obs_wdata[n][1] = wdata_1;
        obs_wdata[n][2] = wdata_2; obs_wdata[n][3] = wdata_3;
        obs_done[n] = done;
        obs_err[n] = err;
        n++;
      end
      tests++;
      if (wen !== ew) begin
        fails++;
        $display("FAIL wen n=%0d: got %b want %b", n, wen, ew);
      end
      tests++;
      if ({waddr_3, waddr_2, waddr_1, waddr_0} !== {exp_waddr[3], exp_waddr[2], exp_waddr[1], exp_waddr[0]}) begin
        fails++;
        $display("FAIL waddr n=%0d: got %h/%h/%h/%h want %h/%h/%h/%h", n,
                 waddr_3, waddr_2, waddr_1, waddr_0, exp_waddr[3], exp_waddr[2], exp_waddr[1], exp_waddr[0]);
      end
      tests++;
      if ({wdata_3, wdata_2, wdata_1, wdata_0} !== {exp_wdata[3], exp_wdata[2], exp_wdata[1], exp_wdata[0]}) begin
        fails++;
        $display("FAIL wdata n=%0d: got %h/%h/%h/%h want %h/%h/%h/%h", n,
                 wdata_3, wdata_2, wdata_1, wdata_0, exp_wdata[3], exp_wdata[2], exp_wdata[1], exp_wdata[0]);
      end
      tests++;
      if (done !== exp_done || busy !== (n < N) || s_ready !== (n < N) || err !== exp_err) begin
        fails++;
        $display("FAIL status n=%0d: done=%b busy=%b s_ready=%b err=%b want %b %b %b %b",
                 n, done, busy, s_ready, err, exp_done, (n < N), (n < N), exp_err);
      end
      if (wen !== 4'b0000) wr_cycles++;
      if (done === 1'b1) done_cnt++;
    end

    if (abort_at < 0) begin
      tests++;
      if (n != N) begin
        fails++;
        $display("FAIL load_timeout: %0d coefficients accepted, want %0d", n, N);
      end
      tests++;
      if (wr_cycles != N || done_cnt != 1) begin
        fails++;
        $display("FAIL write_count: %0d write cycles %0d done pulses, want %0d and 1", wr_cycles, done_cnt, N);
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 128; j++)
          if (seen[i][j] != ((kd || j < 64) ? 1 : 0)) bad_pairs++;
      tests++;
      if (bad_pairs != 0) begin
        fails++;
        $display("FAIL bank_coverage: %0d (bank,addr) pairs with wrong write count, want 0", bad_pairs);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; KD_mode = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_model();
    #2;
    tests++;
    if ({wen, s_ready, busy, done, err} !== 8'h00 ||
        {waddr_3, waddr_2, waddr_1, waddr_0} !== 28'h0 ||
        {wdata_3, wdata_2, wdata_1, wdata_0} !== 48'h0) begin
      fails++;
      $display("FAIL reset_state: wen=%b s_ready=%b busy=%b done=%b err=%b, want all zero", wen, s_ready, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 24'($urandom));
      tests++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || wen !== 4'b0000) begin
        fails++;
        $display("FAIL idle_after_reset: s_ready=%b busy=%b wen=%b, want 0 0 0000", s_ready, busy, wen);
      end
    end
  endtask

  task automatic test_kyber();
    fill_coef(1'b0);
    coef[0]  = 24'h000ABC;
    coef[5]  = 24'h000123;
    coef[10] = 24'd3329;
    coef[11] = 24'd3328;
    run_load(1'b0, 1'b1, 1'b1, -1);
    tests++;
    if (obs_wen[0] !== 4'b0001 || obs_waddr[0][0] !== 7'd0 || obs_wdata[0][0] !== 12'hABC) begin
      fails++;
      $display("FAIL kyber_n0: wen=%b waddr_0=%0d wdata_0=%h, want 0001 0 abc", obs_wen[0], obs_waddr[0][0], obs_wdata[0][0]);
    end
    tests++;
    if (obs_wen[5] !== 4'b0100 || obs_waddr[5][2] !== 7'd1 || obs_wdata[5][2] !== 12'h123) begin
      fails++;
      $display("FAIL kyber_n5: wen=%b waddr_2=%0d wdata_2=%h, want 0100 1 123", obs_wen[5], obs_waddr[5][2], obs_wdata[5][2]);
    end
    tests++;
    if (obs_wen[255] !== 4'b0001 || obs_waddr[255][0] !== 7'd63 || obs_done[255] !== 1'b1) begin
      fails++;
      $display("FAIL kyber_last: wen=%b waddr_0=%0d done=%b, want 0001 63 1", obs_wen[255], obs_waddr[255][0], obs_done[255]);
    end
`ifdef COEF_RANGE_CHK_EN
    tests++;
    if (obs_err[9] !== 1'b0 || obs_err[10] !== 1'b1 || obs_err[255] !== 1'b1) begin
      fails++;
      $display("FAIL kyber_err: err@9=%b err@10=%b err@255=%b, want 0 1 1", obs_err[9], obs_err[10], obs_err[255]);
    end
`else
    tests++;
    if (obs_err[10] !== 1'b0 || obs_err[255] !== 1'b0) begin
      fails++;
      $display("FAIL kyber_err_off: err@10=%b err@255=%b, want 0 0", obs_err[10], obs_err[255]);
    end
`endif
  endtask

  // Starts the Dilithium load in the cycle right after the previous done pulse.
  task automatic test_back_to_back_dilithium();
    fill_coef(1'b1);
    coef[5]  = 24'h123456;
    coef[20] = 24'd8380417;
    coef[21] = 24'd8380416;
    run_load(1'b1, 1'b1, 1'b0, -1);
    tests++;
    if (obs_wen[5] !== 4'b0101 || obs_waddr[5][2] !== 7'd1 || obs_wdata[5][2] !== 12'h456 ||
        obs_waddr[5][0] !== 7'd65 || obs_wdata[5][0] !== 12'h123) begin
      fails++;
      $display("FAIL dil_n5: wen=%b waddr_2=%0d wdata_2=%h waddr_0=%0d wdata_0=%h, want 0101 1 456 65 123",
               obs_wen[5], obs_waddr[5][2], obs_wdata[5][2], obs_waddr[5][0], obs_wdata[5][0]);
    end
  endtask

  task automatic test_reset_mid_load();
    fill_coef(1'b0);
    run_load(1'b0, 1'b1, 1'b0, 100);
    s_valid = 1'b1;
    s_data  = coef[100];
    #2 rst = 1'b1;
    #1;
    clear_model();
    tests++;
    if ({wen, s_ready, busy, done, err} !== 8'h00 ||
        {waddr_3, waddr_2, waddr_1, waddr_0} !== 28'h0 ||
        {wdata_3, wdata_2, wdata_1, wdata_0} !== 48'h0) begin
      fails++;
      $display("FAIL abort_reset: wen=%b s_ready=%b busy=%b done=%b, want all zero", wen, s_ready, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 24'($urandom));
      tests++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || wen !== 4'b0000) begin
        fails++;
        $display("FAIL after_abort: s_ready=%b busy=%b wen=%b, want 0 0 0000", s_ready, busy, wen);
      end
    end
    fill_coef(1'b0);
    run_load(1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_kyber();
    test_back_to_back_dilithium();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
